regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_onehot_chk.sv | 30 +++
 rtl/regfile_sb.sv | 160 ++++++++++++++++
 tb/tb_regfile_sb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and types for regfile_sb and its users.
package rf_pkg;

  localparam int unsigned NREG   = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = $clog2(NREG);
  localparam int unsigned CNT_W  = $clog2(NREG) + 1;

  typedef logic [NREG-1:0]   reg_wl_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [CNT_W-1:0]  reg_cnt_t;

endpackage

// File: rtl/rf_onehot_chk.sv
// Wordline decoder: flags exactly-one-hot inputs and returns the binary index of the set bit.
module rf_onehot_chk #(
  parameter  int unsigned N  = 16,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_wl,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] w_cnt;
  logic [IW-1:0] w_idx;

  always_comb begin
    w_cnt = '0;
    w_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_wl[i]) begin
        w_cnt = w_cnt + CW'(1);
        w_idx = IW'(i);
      end
    end
  end

  assign o_valid = (w_cnt == CW'(1));
  assign o_idx   = w_idx;

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write flop register file with a pending-write scoreboard, same-cycle
// writeback bypass and a sticky protocol-error flag.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = rf_pkg::DATA_W,
  parameter int unsigned NREG   = rf_pkg::NREG
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREG-1:0]           rd_wl_a,
  input  logic [NREG-1:0]           rd_wl_b,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data_a,
  output logic [DATA_W-1:0]         rd_data_b,
  output logic                      rd_valid,
  input  logic                      iss_valid,
  input  logic [NREG-1:0]           iss_wl,
  output logic                      iss_ready,
  input  logic                      wb_valid,
  input  logic [NREG-1:0]           wb_wl,
  input  logic [DATA_W-1:0]         wb_data,
  output logic                      wb_ready,
  output logic [NREG-1:0]           busy,
  output logic [$clog2(NREG):0]     busy_cnt,
  output logic                      err
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned CW = $clog2(NREG) + 1;
  localparam logic [NREG-1:0] MASK_NO_R0 = {{(NREG-1){1'b1}}, 1'b0};

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [CW-1:0]     r_busy_cnt;
  logic              r_err;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;

  logic          w_ra_ok, w_rb_ok, w_iss_ok, w_wb_ok;
  logic [IW-1:0] w_ra_idx, w_rb_idx, w_iss_idx, w_wb_idx;

  rf_onehot_chk #(.N(NREG)) u_chk_rd_a (
    .i_wl    (rd_wl_a),
    .o_valid (w_ra_ok),
    .o_idx   (w_ra_idx)
  );

  rf_onehot_chk #(.N(NREG)) u_chk_rd_b (
    .i_wl    (rd_wl_b),
    .o_valid (w_rb_ok),
    .o_idx   (w_rb_idx)
  );

  rf_onehot_chk #(.N(NREG)) u_chk_iss (
    .i_wl    (iss_wl),
    .o_valid (w_iss_ok),
    .o_idx   (w_iss_idx)
  );

  rf_onehot_chk #(.N(NREG)) u_chk_wb (
    .i_wl    (wb_wl),
    .o_valid (w_wb_ok),
    .o_idx   (w_wb_idx)
  );

  logic              w_wb_acc;
  logic              w_wb_hit;
  logic [NREG-1:0]   w_wb_clr;
  logic              w_iss_ready;
  logic [NREG-1:0]   w_iss_set;
  logic [NREG-1:0]   w_busy_d;
  logic [CW-1:0]     w_busy_cnt_d;
  logic              w_err_d;
  logic [DATA_W-1:0] w_rd_a_d;
  logic [DATA_W-1:0] w_rd_b_d;

  assign w_wb_acc = wb_valid;
  assign w_wb_hit = w_wb_acc & w_wb_ok;
  // Validated one-hot of the register being written back this cycle, else zero.
  assign w_wb_clr = w_wb_hit ? wb_wl : '0;

  assign w_iss_ready = w_iss_ok & (~r_busy[w_iss_idx] | w_wb_clr[w_iss_idx]);
  assign w_iss_set   = (iss_valid & w_iss_ready) ? (iss_wl & MASK_NO_R0) : '0;
  assign w_busy_d    = (r_busy & ~w_wb_clr) | w_iss_set;

  always_comb begin
    w_busy_cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_busy_cnt_d = w_busy_cnt_d + CW'(w_busy_d[i]);
    end
  end

  always_comb begin
    w_rd_a_d = '0;
    if (w_ra_ok && (w_ra_idx != '0)) begin
      w_rd_a_d = w_wb_clr[w_ra_idx] ? wb_data : r_regs[w_ra_idx];
    end
  end

  always_comb begin
    w_rd_b_d = '0;
    if (w_rb_ok && (w_rb_idx != '0)) begin
      w_rd_b_d = w_wb_clr[w_rb_idx] ? wb_data : r_regs[w_rb_idx];
    end
  end

  assign w_err_d = r_err
                 | (rd_en & (~w_ra_ok | ~w_rb_ok))
                 | (w_wb_acc & ~w_wb_ok)
                 | (w_wb_hit & ~r_busy[w_wb_idx]);

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_hit && (w_wb_idx != '0)) begin
      r_regs[w_wb_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= w_busy_d;
      r_busy_cnt <= w_busy_cnt_d;
      r_err      <= w_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data_a <= w_rd_a_d;
        r_rd_data_b <= w_rd_b_d;
      end
    end
  end

  assign rd_data_a = r_rd_data_a;
  assign rd_data_b = r_rd_data_b;
  assign rd_valid  = r_rd_valid;
  assign iss_ready = w_iss_ready;
  assign wb_ready  = 1'b1;
  assign busy      = r_busy;
  assign busy_cnt  = r_busy_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised scoreboard bench for regfile_sb against a behavioural register/busy model.
module tb_regfile_sb;
  import rf_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  reg_wl_t   rd_wl_a = '0, rd_wl_b = '0, iss_wl = '0, wb_wl = '0;
  logic      rd_en = 1'b0, iss_valid = 1'b0, wb_valid = 1'b0;
  reg_data_t wb_data = '0;
  reg_data_t rd_data_a, rd_data_b;
  logic      rd_valid, iss_ready, wb_ready, err;
  reg_wl_t   busy;
  reg_cnt_t  busy_cnt;

  regfile_sb #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_wl_a   (rd_wl_a),
    .rd_wl_b   (rd_wl_b),
    .rd_en     (rd_en),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid),
    .iss_valid (iss_valid),
    .iss_wl    (iss_wl),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_wl     (wb_wl),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .busy      (busy),
    .busy_cnt  (busy_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  reg_data_t   m_regs [NREG];
  reg_wl_t     m_busy;
  bit          m_err;
  logic [31:0] q_rd [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wl_ok(input reg_wl_t wl);
    return $countones(wl) == 1;
  endfunction

  function automatic int wl_idx(input reg_wl_t wl);
    int r = -1;
    for (int i = 0; i < NREG; i++) if (wl[i]) r = i;
    return r;
  endfunction

  function automatic reg_wl_t rand_wl(input bit allow_bad);
    reg_wl_t w;
    if (allow_bad && ($urandom_range(0, 7) == 0)) begin
      if ($urandom_range(0, 1) == 0) w = '0;
      else begin
        w = reg_wl_t'($urandom);
        w[$urandom_range(0, 7)]  = 1'b1;
        w[$urandom_range(8, 15)] = 1'b1;
      end
    end else begin
      w = reg_wl_t'(1) << $urandom_range(0, NREG - 1);
    end
    return w;
  endfunction

  // Value a read port must return given the model state before this cycle's writeback.
  function automatic reg_data_t exp_rd(input reg_wl_t wl, input bit wv, input reg_wl_t wwl,
                                       input reg_data_t wd);
    int k;
    if (!wl_ok(wl)) return '0;
    k = wl_idx(wl);
    if (k == 0) return '0;
    if (wv && (wwl == wl)) return wd;
    return m_regs[k];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_busy = '0;
    m_err  = 1'b0;
    q_rd.delete();
  endtask

  task automatic drive_idle();
    rd_en = 1'b0; rd_wl_a = '0; rd_wl_b = '0;
    iss_valid = 1'b0; iss_wl = '0;
    wb_valid = 1'b0; wb_wl = '0; wb_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_cycle(input bit t_re, input reg_wl_t t_wa, input reg_wl_t t_wb,
                          input bit t_iv, input reg_wl_t t_iwl,
                          input bit t_wv, input reg_wl_t t_wwl, input reg_data_t t_wd);
    bit exp_rdy;
    int k;
    @(negedge clk);
    rd_en = t_re; rd_wl_a = t_wa; rd_wl_b = t_wb;
    iss_valid = t_iv; iss_wl = t_iwl;
    wb_valid = t_wv; wb_wl = t_wwl; wb_data = t_wd;
    #1;
    exp_rdy = wl_ok(t_iwl) && (!m_busy[wl_idx(t_iwl)] || (t_wv && (t_wwl == t_iwl)));
    chk("iss_ready", iss_ready, exp_rdy);
    chk("wb_ready", wb_ready, 1);
    if (t_re) begin
      q_rd.push_back({exp_rd(t_wa, t_wv, t_wwl, t_wd), exp_rd(t_wb, t_wv, t_wwl, t_wd)});
      if (!wl_ok(t_wa) || !wl_ok(t_wb)) m_err = 1'b1;
    end
    if (t_wv) begin
      if (!wl_ok(t_wwl)) m_err = 1'b1;
      else begin
        k = wl_idx(t_wwl);
        if (!m_busy[k]) m_err = 1'b1;
        if (k != 0) m_regs[k] = t_wd;
        m_busy[k] = 1'b0;
      end
    end
    if (t_iv && exp_rdy && (wl_idx(t_iwl) != 0)) m_busy[wl_idx(t_iwl)] = 1'b1;
    @(posedge clk);
    #1;
    chk("busy", busy, m_busy);
    chk("busy_cnt", busy_cnt, $countones(m_busy));
    chk("err", err, m_err);
  endtask

  task automatic idle_cycle();
    do_cycle(0, '0, '0, 0, '0, 0, '0, '0);
  endtask

  // Monitor: every cycle rd_valid must match a pending expectation, which is then consumed.
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    chk("rd_valid", rd_valid, q_rd.size() != 0);
    if (q_rd.size() != 0) begin
      e = q_rd.pop_front();
      if (rd_valid) begin
        chk("rd_data_a", rd_data_a, e[31:16]);
        chk("rd_data_b", rd_data_b, e[15:0]);
      end
    end
  end

  initial begin
    reg_wl_t   wa, wb2, iw, ww;
    reg_data_t wd;
    bit        wv;
    int        cand [$];

    model_reset();
    #2;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_busy_cnt", busy_cnt, 0);
    chk("reset_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    iss_wl = 16'h0002;
    #1;
    chk("post_reset_iss_ready", iss_ready, 1);

    // Scoreboard issue / re-issue / same-cycle writeback release.
    do_cycle(0, '0, '0, 1, 16'h0010, 0, '0, '0);
    chk("iss_busy", busy, 16'h0010);
    chk("iss_busy_cnt", busy_cnt, 1);
    do_cycle(0, '0, '0, 1, 16'h0010, 0, '0, '0);
    do_cycle(0, '0, '0, 1, 16'h0010, 1, 16'h0010, 16'h5555);
    chk("iss_wb_busy", busy, 16'h0010);

    // Plain write then read, then same-cycle bypass.
    do_cycle(0, '0, '0, 0, '0, 1, 16'h0008, 16'hBEEF);
    do_cycle(1, 16'h0008, 16'h0010, 0, '0, 0, '0, '0);
    do_cycle(1, 16'h0010, 16'h0020, 0, '0, 1, 16'h0020, 16'h1234);
    idle_cycle();

    // Multi-hot read, and register 0 stays zero after a write.
    do_cycle(1, 16'h0003, 16'h0008, 0, '0, 0, '0, '0);
    do_cycle(0, '0, '0, 0, '0, 1, 16'h0001, 16'h7777);
    do_cycle(1, 16'h0001, 16'h0001, 0, '0, 0, '0, '0);
    idle_cycle();
    chk("err_sticky", err, 1);

    // Protocol-clean random traffic: writebacks only to busy registers.
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      cand.delete();
      for (int i = 0; i < NREG; i++) if (m_busy[i]) cand.push_back(i);
      wv = (cand.size() != 0) && ($urandom_range(0, 1) == 1);
      ww = wv ? (reg_wl_t'(1) << cand[$urandom_range(0, cand.size() - 1)]) : '0;
      wd = reg_data_t'($urandom);
      iw = rand_wl(0);
      do_cycle($urandom_range(0, 1) == 1, rand_wl(0), rand_wl(0),
               $urandom_range(0, 1) == 1, iw, wv, ww, wd);
    end

    // Unconstrained random traffic including invalid wordlines.
    for (int n = 0; n < 300; n++) begin
      wa  = rand_wl(1);
      wb2 = rand_wl(1);
      iw  = rand_wl(1);
      ww  = rand_wl(1);
      wd  = reg_data_t'($urandom);
      do_cycle($urandom_range(0, 1) == 1, wa, wb2, $urandom_range(0, 1) == 1, iw,
               $urandom_range(0, 2) != 0, ww, wd);
    end
    idle_cycle();

    // Asynchronous reset in the middle of a cycle with busy/err/rd_valid set.
    apply_reset();
    do_cycle(0, '0, '0, 1, 16'h0010, 1, 16'h0100, 16'hAAAA);
    do_cycle(0, '0, '0, 1, 16'h0020, 0, '0, '0);
    do_cycle(0, '0, '0, 1, 16'h0040, 0, '0, '0);
    do_cycle(0, '0, '0, 1, 16'h0080, 0, '0, '0);
    do_cycle(1, 16'h0000, 16'h0010, 0, '0, 0, '0, '0);
    chk("pre_reset_busy", busy, 16'h00F0);
    chk("pre_reset_err", err, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rd_valid", rd_valid, 0);
    chk("async_rd_data_a", rd_data_a, 0);
    chk("async_rd_data_b", rd_data_b, 0);
    chk("async_busy", busy, 0);
    chk("async_busy_cnt", busy_cnt, 0);
    chk("async_err", err, 0);
    @(negedge clk);
    wb_valid = 1'b1; wb_wl = 16'h0200; wb_data = 16'hC0DE;
    iss_valid = 1'b1; iss_wl = 16'h0400;
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    do_cycle(1, 16'h0200, 16'h0100, 0, '0, 0, '0, '0);
    idle_cycle();
    idle_cycle();
    chk("queue_drained", q_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
